unshift_serial: RTL and testbench
=================================

UNSHIFT_SERIAL -- requirements
Module: unshift_serial

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter AMT_W, default 3, shift-amount width in bits; the maximum shift is 2^AMT_W-1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 din  input  WIDTH  word to shift right.
REQ-009 amt  input  AMT_W  right-shift distance.
REQ-010 arith  input  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 dout  output  WIDTH  shifted result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE, encoded as a registered state.
REQ-016 A request SHALL be accepted on a clock edge where in_valid and in_ready are both high; din, amt and arith are captured into a data register, a down-counter and a mode flag.
REQ-017 in_ready SHALL be high in IDLE, and in DONE when out_ready is high, and low otherwise.
REQ-018 On accept with amt=0, next state SHALL be DONE; with amt>0, next state SHALL be SHIFT.
REQ-019 In SHIFT, each cycle SHALL shift the data register right by exactly 1 and decrement the counter.
  - Fill bit is data[WIDTH-1] when the mode flag is 1, else 0.
  - The LSB is discarded.
REQ-020 SHIFT SHALL move to DONE on the cycle the counter decrements from 1 to 0.
REQ-021 Latency from the accept edge to out_valid high SHALL be amt+1 cycles; amt=7 gives 8 cycles.
REQ-022 out_valid SHALL be high only in DONE, and dout SHALL equal the data register whenever out_valid is high.
REQ-023 dout SHALL hold stable in DONE while out_ready is low, with no limit on stall length.
REQ-024 DONE with out_ready high and no new accept SHALL go to IDLE.
REQ-025 DONE with out_ready high and a simultaneous accept SHALL load the new request and go to SHIFT or DONE per REQ-018, with no idle bubble.
REQ-026 Input changes outside an accept edge SHALL NOT affect an operation in progress.
REQ-027 Arithmetic width rule: the result SHALL equal din >> amt (logical) or $signed(din) >>> amt (arithmetic), truncated to WIDTH; amt never exceeds WIDTH-1 for the defaults.

Reset
REQ-028 While rst_n is low, the block SHALL hold the following values, independent of clk:
  - state = IDLE, counter = 0, data register = 0, mode flag = 0;
  - in_ready = 0, out_valid = 0, dout = 0, busy = 0.
REQ-029 Assertion of rst_n mid-SHIFT or mid-DONE SHALL abort the operation and discard its result, with no out_valid produced.
REQ-030 After rst_n deasserts, in_ready SHALL rise on the first clk edge, and the first accept SHALL be possible on the following edge.

Verification
REQ-031 Logical shift: din=0x8001, amt=3, arith=0 -> out_valid on cycle 4 after accept, dout=0x1000.
REQ-032 Arithmetic shift: din=0x8001, amt=3, arith=1 -> dout=0xF000; din=0x7FFF, amt=7, arith=1 -> dout=0x00FF after 8 cycles.
REQ-033 Zero shift: din=0xABCD, amt=0 -> out_valid one cycle after accept, dout=0xABCD, and busy high for exactly that cycle when out_ready=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> dout, out_valid and busy stay constant and in_ready stays low; release out_ready -> the result is consumed once.
REQ-035 Back-to-back: present a second request with in_valid=1 during DONE with out_ready=1 -> it is accepted that cycle with no IDLE cycle, and both results are correct and in order.
REQ-036 Reset mid-operation: assert rst_n low during SHIFT of amt=5 -> all outputs go to zero immediately; after release, no stale result appears and a new request completes normally.

Source files
------------

// File: rtl/unshift_serial.sv
// Serial right shifter: shifts a captured word one bit per clock, logical or
// arithmetic, and hands the result over a valid/ready pair.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request
//   SHIFT | data register shifting right one bit per cycle, counter > 0
//   DONE  | result presented on dout, held until out_ready
module unshift_serial #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             armed_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             mode_q;
  logic             accept;

  // armed_q keeps in_ready low through reset and releases it on the first edge
  assign in_ready  = armed_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign dout      = out_valid ? data_q : '0;
  assign busy      = (state_q != IDLE);

  // Ready enable: set once after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; an accept in DONE reloads without passing through IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (accept)         state_d = (amt == '0) ? DONE : SHIFT;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, otherwise shift one bit per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      data_q <= din;
      cnt_q  <= amt;
      mode_q <= arith;
    end else if (state_q == SHIFT) begin
      data_q <= {(mode_q ? data_q[WIDTH-1] : 1'b0), data_q[WIDTH-1:1]};
      cnt_q  <= cnt_q - AMT_W'(1);
    end
  end

endmodule

// File: tb/tb_unshift_serial.sv
// Testbench for unshift_serial: directed cases plus randomized requests with
// random backpressure, checked against an arithmetic reference shift.
module tb_unshift_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [2:0]  amt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  unshift_serial #(.WIDTH(16), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .amt(amt), .arith(arith), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int a, input logic ar);
    logic signed [15:0] s;
    s = d;
    if (ar) return 16'(s >>> a);
    return d >> a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    din   = 16'($urandom);
    amt   = 3'($urandom);
    arith = 1'($urandom);
  endtask

  // Wait (bounded) for out_valid; returns cycles counted from the accept edge
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      scramble();
      n++;
    end
  endtask

  // One complete request; called and returns at a falling edge
  task automatic run_op(input logic [15:0] d, input int a, input logic ar, input int hold);
    logic [15:0] exp;
    int n;
    exp       = ref_shift(d, a, ar);
    out_ready = (hold == 0);
    din = d; amt = 3'(a); arith = ar; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    wait_valid(n);
    chk("latency", n, a + 1);
    chk("dout", dout, exp);
    chk("busy_done", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      chk("stall_valid", out_valid, 1);
      chk("stall_dout", dout, exp);
      chk("stall_busy", busy, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("consumed_once", out_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; amt = '0; arith = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_post", in_ready, 1);

    // Directed cases
    run_op(16'h8001, 3, 1'b0, 0);
    run_op(16'h8001, 3, 1'b1, 0);
    run_op(16'h7FFF, 7, 1'b1, 0);
    run_op(16'hABCD, 0, 1'b0, 0);
    run_op(16'hC3A5, 6, 1'b1, 5);

    // Back-to-back: new request accepted in DONE with out_ready high
    out_ready = 1'b1;
    din = 16'h1234; amt = 3'd2; arith = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b1_dout", dout, ref_shift(16'h1234, 2, 1'b0));
    din = 16'h8F00; amt = 3'd4; arith = 1'b1; in_valid = 1'b1;
    chk("b2b2_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b2_no_bubble", busy, 1);
    chk("b2b2_shifting", out_valid, 0);
    wait_valid(n);
    chk("b2b2_latency", n, 5);
    chk("b2b2_dout", dout, ref_shift(16'h8F00, 4, 1'b1));
    din = 16'h00F0; amt = 3'd0; arith = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b3_valid", out_valid, 1);
    chk("b2b3_dout", dout, 16'h00F0);
    @(negedge clk);
    chk("b2b3_consumed", out_valid, 0);

    // Reset during SHIFT aborts the operation
    out_ready = 1'b0;
    din = 16'hF0F0; amt = 3'd5; arith = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_result", stale, 0);
    run_op(16'h0F0F, 5, 1'b0, 1);

    // Randomized requests with random backpressure
    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
